// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and iteration count for the multiply/divide unit
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam int MDU_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        op_signed, op_div;
    logic [31:0] rs_abs, rt_abs;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_t;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [63:0] prod;
    logic [31:0] quot, rem;

    assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign op_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    assign rs_abs    = (op_signed && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
    assign rt_abs    = (op_signed && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;

    // Multiply: add multiplicand into the upper half, shift the 33-bit sum back in.
    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? a_q : 32'd0)};
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Restoring divide: partial remainder in the upper half needs a 33rd bit before compare.
    assign div_t    = acc_q[63:31];
    assign div_ge   = div_t >= {1'b0, b_q};
    assign div_rem  = div_t[31:0] - b_q;
    assign div_next = div_ge ? {div_rem, acc_q[30:0], 1'b1}
                             : {div_t[31:0], acc_q[30:0], 1'b0};

    assign prod = (neg_a_q ^ neg_b_q) ? (~acc_q + 64'd1) : acc_q;
    assign quot = (neg_a_q ^ neg_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem  = neg_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    is_div_d = op_div;
                    neg_a_d  = op_signed && rs_data[31];
                    neg_b_d  = op_signed && rt_data[31];
                    a_d      = rs_abs;
                    b_d      = rt_abs;
                    cnt_d    = 6'd0;
                    acc_d    = op_div ? {32'd0, rs_abs} : {32'd0, rt_abs};
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(MDU_ITERS - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = (b_q == 32'd0) ? 32'hFFFF_FFFF : quot;
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_q    <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic reference
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    mult_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            default: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        eh = p[63:32];
        el = p[31:0];
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called #1 after the start edge; poke drives a second start and MTHI in cycle 5.
    task automatic wait_result(input string tag, input logic [31:0] eh, input logic [31:0] el, input bit poke);
        int  n = 0;
        bit  busy_ok = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (poke && n == 5) begin
                start = 1'b1; op = 2'b00; rs_data = 32'h1234_5678; rt_data = 32'h9;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (poke && n == 6) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_hold"}, {hi, lo}, {eh, el});
    endtask

    initial begin
        logic [31:0] eh, el, a, b;
        logic [1:0]  o;
        bit          done_seen;

        rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #1;
        check("reset_outputs", {30'd0, busy, done, hi}, 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // First edge after reset release accepts the start.
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("first_start_busy", 64'(busy), 64'd1);
        wait_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
        wait_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

        launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        launch(2'b11, 32'h0000_0064, 32'h0000_0000);
        wait_result("divu_zero", 32'h0000_0064, 32'hFFFF_FFFF, 1'b0);

        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0);

        launch(2'b10, 32'hFFFF_FF9C, 32'h0000_0000);
        wait_result("div_zero_neg", 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b0);

        launch(2'b11, 32'd100, 32'd7);
        wait_result("divu_poke", 32'h0000_0002, 32'h0000_000E, 1'b1);

        // MTHI/MTLO in idle, then MTHI coinciding with a start.
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0001;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_write", {hi, lo}, {32'hA5A5_0001, 32'hA5A5_0001});
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h0BAD_F00D;
        start = 1'b1; op = 2'b01; rs_data = 32'd6; rt_data = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        check("mt_with_start", 64'(hi), 64'h0BAD_F00D);
        wait_result("mt_then_multu", 32'd0, 32'd42, 1'b0);

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            if (i % 7 == 3) a = 32'h8000_0000;
            ref_op(o, a, b, eh, el);
            launch(o, a, b);
            wait_result($sformatf("rand%0d_op%0d", i, o), eh, el, 1'b0);
        end

        // Asynchronous reset in cycle 10 of a MULTU aborts it.
        launch(2'b01, 32'hFFFF_FFFF, 32'd3);
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || hi !== 32'd0 || lo !== 32'd0) done_seen = 1'b1;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check("abort_mtlo", {hi, lo}, {32'd0, 32'h0000_1234});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
